// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: the hex glyph table,
// segment bit positions and a width helper.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'b000_0000;

    // Packed MSB-first: the first row is glyph F, the last row is glyph 0.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b0001101,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational hex nibble to 7-segment glyph encoder (segment a on bit 6).
import seg7_pkg::*;

module seg7_hex_enc (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: one digit per refresh slot, with
// frame-synchronous loading, leading-zero blanking and pin polarity control.
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0,
    parameter bit LZ_BLANK       = 1'b1,
    parameter bit FRAME_SYNC     = 1'b1
) (
    input  logic                  clkIN,
    input  logic                  rstIN_n,
    input  logic [4*DIGITS-1:0]   dataIN,
    input  logic                  validIN,
    input  logic [DIGITS-1:0]     dpIN,
    input  logic                  blankIN,
    output logic [6:0]            segOUT,
    output logic                  dpOUT,
    output logic [DIGITS-1:0]     digOUT,
    output logic                  frameOUT
);

    localparam int IDX_W = clog2(DIGITS);
    localparam int PRE_W = clog2(SCAN_DIV);

    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_ACTIVE_LOW}};

    logic [PRE_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic                w_tc;
    logic                w_wrap;

    logic [4*DIGITS-1:0] r_disp_data;
    logic [DIGITS-1:0]   r_disp_dp;
    logic [4*DIGITS-1:0] r_pend_data;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pend_valid;

    logic                w_lead;
    logic [DIGITS-1:0]   w_lz_blank;
    logic [3:0]          w_nib;
    logic                w_dp_sel;
    logic                w_blank_sel;
    logic [DIGITS-1:0]   w_dig_sel;
    logic                w_off;
    logic [6:0]          w_seg_raw;
    logic [6:0]          w_seg;
    logic                w_dp;
    logic [DIGITS-1:0]   w_dig;

    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig;
    logic                r_frame;

    assign w_tc   = (r_presc == PRE_W'(SCAN_DIV - 1));
    assign w_wrap = w_tc && (r_idx == IDX_W'(DIGITS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clkIN or negedge rstIN_n) begin
        if (!rstIN_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

    // A strobe landing on the wrap edge bypasses the pending stage entirely.
    always_ff @(posedge clkIN or negedge rstIN_n) begin
        if (!rstIN_n) begin
            r_disp_data  <= '0;
            r_disp_dp    <= '0;
            r_pend_data  <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (FRAME_SYNC) begin
            if (validIN && w_wrap) begin
                r_disp_data  <= dataIN;
                r_disp_dp    <= dpIN;
                r_pend_valid <= 1'b0;
            end else if (w_wrap && r_pend_valid) begin
                r_disp_data  <= r_pend_data;
                r_disp_dp    <= r_pend_dp;
                r_pend_valid <= 1'b0;
            end else if (validIN) begin
                r_pend_data  <= dataIN;
                r_pend_dp    <= dpIN;
                r_pend_valid <= 1'b1;
            end
        end else if (validIN) begin
            r_disp_data <= dataIN;
            r_disp_dp   <= dpIN;
        end
    end

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_lz_blank = '0;
        w_lead     = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_lead = w_lead && (r_disp_data[4*i +: 4] == 4'h0) && !r_disp_dp[i];
            if (LZ_BLANK && (i > 0)) w_lz_blank[i] = w_lead;
        end
    end

    always_comb begin
        w_nib       = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_dig_sel   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib        = r_disp_data[4*i +: 4];
                w_dp_sel     = r_disp_dp[i];
                w_blank_sel  = w_lz_blank[i];
                w_dig_sel[i] = 1'b1;
            end
        end
    end

    seg7_hex_enc u_enc (
        .i_nib (w_nib),
        .o_seg (w_seg_raw)
    );

    assign w_off = blankIN || w_blank_sel;
    assign w_seg = w_off ? SEG_BLANK : w_seg_raw;
    assign w_dp  = !w_off && w_dp_sel;
    assign w_dig = w_off ? '0 : w_dig_sel;

    // Polarity is folded in here only; XOR with the off-level flips active-low pins.
    always_ff @(posedge clkIN or negedge rstIN_n) begin
        if (!rstIN_n) begin
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_dig   <= DIG_OFF;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg ^ SEG_OFF;
            r_dp    <= w_dp ^ DP_OFF;
            r_dig   <= w_dig ^ DIG_OFF;
            r_frame <= w_wrap;
        end
    end

    assign segOUT   = r_seg;
    assign dpOUT    = r_dp;
    assign digOUT   = r_dig;
    assign frameOUT = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three instances (immediate load, frame-synced,
// active-low pins) share stimulus and are compared every cycle to a timeline model.
`timescale 1ns/1ps

module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] dataIN = '0;
    logic        validIN = 1'b0;
    logic [3:0]  dpIN = '0;
    logic        blankIN = 1'b0;

    logic [6:0] seg_fs0, seg_fs1, seg_pol;
    logic       dp_fs0, dp_fs1, dp_pol;
    logic [3:0] dig_fs0, dig_fs1, dig_pol;
    logic       frm_fs0, frm_fs1, frm_pol;

    int checks = 0;
    int failures = 0;

    // Model state: edges since reset release, displayed value per load mode.
    int          m_cyc;
    logic [15:0] d0, d1, pend;
    logic [3:0]  p0, p1, pend_dp;
    bit          pflag;
    bit          cur_blank;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0),
                       .LZ_BLANK(1'b1), .FRAME_SYNC(1'b0)) u_fs0 (
        .clkIN(clk), .rstIN_n(rst_n), .dataIN(dataIN), .validIN(validIN), .dpIN(dpIN),
        .blankIN(blankIN), .segOUT(seg_fs0), .dpOUT(dp_fs0), .digOUT(dig_fs0), .frameOUT(frm_fs0));

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0),
                       .LZ_BLANK(1'b1), .FRAME_SYNC(1'b1)) u_fs1 (
        .clkIN(clk), .rstIN_n(rst_n), .dataIN(dataIN), .validIN(validIN), .dpIN(dpIN),
        .blankIN(blankIN), .segOUT(seg_fs1), .dpOUT(dp_fs1), .digOUT(dig_fs1), .frameOUT(frm_fs1));

    seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1),
                       .LZ_BLANK(1'b1), .FRAME_SYNC(1'b0)) u_pol (
        .clkIN(clk), .rstIN_n(rst_n), .dataIN(dataIN), .validIN(validIN), .dpIN(dpIN),
        .blankIN(blankIN), .segOUT(seg_pol), .dpOUT(dp_pol), .digOUT(dig_pol), .frameOUT(frm_pol));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b0001101;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Positive-true view of what the pins should show for one digit slot.
    function automatic void model_out(input logic [15:0] d, input logic [3:0] p, input int idx,
                                      input bit b, output logic [6:0] s, output logic dpo,
                                      output logic [3:0] g);
        bit lz;
        lz = (idx > 0);
        for (int j = idx; j < 4; j++)
            if (d[j*4 +: 4] != 4'h0 || p[j]) lz = 1'b0;
        if (b || lz) begin
            s = 7'b0; dpo = 1'b0; g = 4'b0;
        end else begin
            s = hex7(d[idx*4 +: 4]); dpo = p[idx]; g = 4'(1 << idx);
        end
    endfunction

    task automatic reset_model();
        m_cyc = 0;
        d0 = '0; p0 = '0; d1 = '0; p1 = '0; pend = '0; pend_dp = '0; pflag = 1'b0;
    endtask

    task automatic check_reset_pins(input string when);
        check({when, "_fs0_seg"}, 32'(seg_fs0), 32'h00);
        check({when, "_fs0_dig"}, 32'(dig_fs0), 32'h0);
        check({when, "_fs0_dp"},  32'(dp_fs0),  32'h0);
        check({when, "_fs0_frm"}, 32'(frm_fs0), 32'h0);
        check({when, "_fs1_dig"}, 32'(dig_fs1), 32'h0);
        check({when, "_fs1_frm"}, 32'(frm_fs1), 32'h0);
        check({when, "_pol_seg"}, 32'(seg_pol), 32'h7F);
        check({when, "_pol_dp"},  32'(dp_pol),  32'h1);
        check({when, "_pol_dig"}, 32'(dig_pol), 32'hF);
    endtask

    // Reset asserted and released between clock edges; pins must go off at once.
    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; validIN = 1'b0;
        #1 check_reset_pins("rst_async");
        repeat (2) @(posedge clk);
        #1 check_reset_pins("rst_held");
        @(posedge clk); #2;
        rst_n = 1'b1;
        reset_model();
    endtask

    // One clock: drive at negedge, predict from pre-edge model state, compare after the edge.
    task automatic cycle(input bit v, input logic [15:0] d, input logic [3:0] p);
        logic [6:0] es, ps;
        logic       ed, pd;
        logic [3:0] eg, pg;
        int  idx;
        bit  wrap;
        @(negedge clk);
        validIN = v; dataIN = d; dpIN = p; blankIN = cur_blank;
        idx  = (m_cyc / 4) % 4;
        wrap = (m_cyc % 16) == 15;
        @(posedge clk); #1;

        model_out(d0, p0, idx, cur_blank, es, ed, eg);
        check("fs0_seg", 32'(seg_fs0), 32'(es));
        check("fs0_dp",  32'(dp_fs0),  32'(ed));
        check("fs0_dig", 32'(dig_fs0), 32'(eg));
        check("fs0_frm", 32'(frm_fs0), 32'(wrap));
        ps = ~es; pd = ~ed; pg = ~eg;
        check("pol_seg", 32'(seg_pol), 32'(ps));
        check("pol_dp",  32'(dp_pol),  32'(pd));
        check("pol_dig", 32'(dig_pol), 32'(pg));
        check("pol_frm", 32'(frm_pol), 32'(wrap));
        model_out(d1, p1, idx, cur_blank, es, ed, eg);
        check("fs1_seg", 32'(seg_fs1), 32'(es));
        check("fs1_dp",  32'(dp_fs1),  32'(ed));
        check("fs1_dig", 32'(dig_fs1), 32'(eg));
        check("fs1_frm", 32'(frm_fs1), 32'(wrap));

        if (v) begin d0 = d; p0 = p; end
        if (wrap) begin
            if (v) begin d1 = d; p1 = p; end
            else if (pflag) begin d1 = pend; p1 = pend_dp; end
            pflag = 1'b0;
        end else if (v) begin
            pend = d; pend_dp = p; pflag = 1'b1;
        end
        m_cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic idle_until(input int phase);
        for (int k = 0; k < 16 && (m_cyc % 16) != phase; k++) idle(1);
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rp;
        cur_blank = 1'b0;
        reset_model();

        do_reset();
        idle(20);

        cycle(1'b1, 16'h1A3F, 4'b0000);
        idle(40);

        cycle(1'b1, 16'h0005, 4'b0000);
        idle(20);
        cycle(1'b1, 16'h0005, 4'b0010);
        idle(20);

        idle_until(3);
        cycle(1'b1, 16'h1111, 4'b0000);
        idle(2);
        cycle(1'b1, 16'h2222, 4'b0000);
        idle(24);
        idle_until(15);
        cycle(1'b1, 16'h3333, 4'b0100);
        idle(20);

        idle(7);
        do_reset();
        idle(10);

        cur_blank = 1'b0;
        cycle(1'b1, 16'h8888, 4'b0000);
        idle(18);
        cur_blank = 1'b1;
        idle(34);
        cur_blank = 1'b0;
        idle(18);

        repeat (220) begin
            rd = 16'($urandom);
            case ($urandom % 3)
                0: rd = rd & 16'h00FF;
                1: rd = rd & 16'h000F;
                default: ;
            endcase
            rp = (($urandom % 4) == 0) ? 4'($urandom) : 4'b0000;
            cur_blank = (($urandom % 12) == 0);
            cycle((($urandom % 6) == 0), rd, rp);
        end
        cur_blank = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
